// File: rtl/multi_channel_debouncer_if.sv
// Debouncer data-path bundle: raw inputs and enable in, filtered levels, edge pulses and aggregate flags out.
// No flow control; master drives inputs, slave (the debouncer) drives outputs.
interface multi_channel_debouncer_if #(
  parameter int WIDTH = 4
);
  logic [WIDTH-1:0] sig_in;
  logic             enable;
  logic [WIDTH-1:0] sig_out;
  logic [WIDTH-1:0] rise_pulse;
  logic [WIDTH-1:0] fall_pulse;
  logic             key_pressed;
  logic             multi_pressed;

  modport master (
    output sig_in, enable,
    input  sig_out, rise_pulse, fall_pulse, key_pressed, multi_pressed
  );

  modport slave (
    input  sig_in, enable,
    output sig_out, rise_pulse, fall_pulse, key_pressed, multi_pressed
  );
endinterface

// File: rtl/multi_channel_debouncer.sv
// WIDTH-channel synchronise-and-debounce filter with press/release pulses and pressed/multi-pressed flags.
// Latency SYNC_STAGES+STABLE_CYCLES edges per accepted level; no backpressure, enable=0 freezes outputs.
module multi_channel_debouncer #(
  parameter int WIDTH         = 4,
  parameter int STABLE_CYCLES = 16,
  parameter int SYNC_STAGES   = 2,
  parameter int ACTIVE_HIGH   = 1
) (
  input  logic                         clk,
  input  logic                         reset,
  multi_channel_debouncer_if.slave     bus
);

  localparam int               CW       = $clog2(STABLE_CYCLES) + 1;
  localparam logic [CW-1:0]    CNT_LAST = CW'(STABLE_CYCLES - 1);
  // Reset value for the synchroniser is the inactive raw level, so no false press on release.
  localparam logic [WIDTH-1:0] INACTIVE = {WIDTH{ACTIVE_HIGH == 0}};

  logic [WIDTH-1:0] sync_q [SYNC_STAGES];
  logic [WIDTH-1:0] sync_d [SYNC_STAGES];
  logic [CW-1:0]    cnt_q  [WIDTH];
  logic [CW-1:0]    cnt_d  [WIDTH];
  logic [WIDTH-1:0] sig_out_q, sig_out_d;
  logic [WIDTH-1:0] rise_q, rise_d;
  logic [WIDTH-1:0] fall_q, fall_d;
  logic [WIDTH-1:0] syn;
  logic             key_c;
  logic             multi_c;

  always_comb begin
    sync_d[0] = bus.sig_in;
    for (int s = 1; s < SYNC_STAGES; s++) begin
      sync_d[s] = sync_q[s-1];
    end
  end

  assign syn = (ACTIVE_HIGH != 0) ? sync_q[SYNC_STAGES-1] : ~sync_q[SYNC_STAGES-1];

  always_comb begin
    sig_out_d = sig_out_q;
    rise_d    = '0;
    fall_d    = '0;
    for (int i = 0; i < WIDTH; i++) begin
      cnt_d[i] = cnt_q[i];
      if (!bus.enable || (syn[i] == sig_out_q[i])) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == CNT_LAST) begin
        sig_out_d[i] = syn[i];
        cnt_d[i]     = '0;
        rise_d[i]    = syn[i];
        fall_d[i]    = ~syn[i];
      end else begin
        cnt_d[i] = cnt_q[i] + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int s = 0; s < SYNC_STAGES; s++) begin
        sync_q[s] <= INACTIVE;
      end
      for (int i = 0; i < WIDTH; i++) begin
        cnt_q[i] <= '0;
      end
      sig_out_q <= '0;
      rise_q    <= '0;
      fall_q    <= '0;
    end else begin
      for (int s = 0; s < SYNC_STAGES; s++) begin
        sync_q[s] <= sync_d[s];
      end
      for (int i = 0; i < WIDTH; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
      sig_out_q <= sig_out_d;
      rise_q    <= rise_d;
      fall_q    <= fall_d;
    end
  end

  // Running OR catches the second set bit without a population count.
  always_comb begin
    key_c   = 1'b0;
    multi_c = 1'b0;
    for (int i = 0; i < WIDTH; i++) begin
      multi_c = multi_c | (key_c & sig_out_q[i]);
      key_c   = key_c | sig_out_q[i];
    end
  end

  assign bus.sig_out       = sig_out_q;
  assign bus.rise_pulse    = rise_q;
  assign bus.fall_pulse    = fall_q;
  assign bus.key_pressed   = key_c;
  assign bus.multi_pressed = multi_c;

endmodule

// File: tb/tb_multi_channel_debouncer.sv
// Directed bench: active-high instance for press/bounce/multi/enable/reset cases, active-low instance for polarity.
// Inputs change and outputs are sampled 1 time unit after each rising edge.
module tb_multi_channel_debouncer;

  logic clk = 1'b0;
  logic reset;
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  multi_channel_debouncer_if #(.WIDTH(4)) bus_a ();
  multi_channel_debouncer_if #(.WIDTH(4)) bus_b ();

  multi_channel_debouncer #(
    .WIDTH(4), .STABLE_CYCLES(4), .SYNC_STAGES(2), .ACTIVE_HIGH(1)
  ) u_dut_a (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_a)
  );

  multi_channel_debouncer #(
    .WIDTH(4), .STABLE_CYCLES(4), .SYNC_STAGES(2), .ACTIVE_HIGH(0)
  ) u_dut_b (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_b)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Advance edge by edge until sig_out equals exp; edges = -1 if the budget runs out.
  task automatic wait_out(input bit sel_b, input logic [3:0] exp, input int max_edges,
                          output int edges, output logic [3:0] rise, output logic [3:0] fall);
    bit found;
    found = 1'b0;
    edges = 0;
    rise  = '0;
    fall  = '0;
    while (!found && edges < max_edges) begin
      tick();
      edges++;
      if ((sel_b ? bus_b.sig_out : bus_a.sig_out) == exp) begin
        found = 1'b1;
        rise  = sel_b ? bus_b.rise_pulse : bus_a.rise_pulse;
        fall  = sel_b ? bus_b.fall_pulse : bus_a.fall_pulse;
      end
    end
    if (!found) edges = -1;
  endtask

  int         e;
  int         bad;
  logic [3:0] r;
  logic [3:0] f;

  initial begin
    reset         = 1'b0;
    bus_a.sig_in  = 4'b0000;
    bus_a.enable  = 1'b1;
    bus_b.sig_in  = 4'b1111;
    bus_b.enable  = 1'b1;

    // Reset
    #1;
    chk("rst_async_out", 32'(bus_a.sig_out), 32'h0);
    tick();
    tick();
    chk("rst_out",    32'(bus_a.sig_out), 32'h0);
    chk("rst_pulses", 32'({bus_a.rise_pulse, bus_a.fall_pulse}), 32'h0);
    chk("rst_flags",  32'({bus_a.key_pressed, bus_a.multi_pressed}), 32'h0);
    chk("rst_pol_out", 32'(bus_b.sig_out), 32'h0);
    reset = 1'b1;
    tick();
    chk("rel_out", 32'({bus_a.sig_out, bus_a.rise_pulse, bus_a.fall_pulse}), 32'h0);

    // Clean press
    bus_a.sig_in = 4'b0001;
    wait_out(1'b0, 4'b0001, 12, e, r, f);
    chk("press_lat",   32'(e), 32'd6);
    chk("press_rise",  32'(r), 32'h1);
    chk("press_fall",  32'(f), 32'h0);
    chk("press_key",   32'(bus_a.key_pressed), 32'h1);
    chk("press_multi", 32'(bus_a.multi_pressed), 32'h0);
    tick();
    chk("press_rise_1cyc", 32'(bus_a.rise_pulse), 32'h0);
    chk("press_hold",      32'(bus_a.sig_out), 32'h1);

    // Release
    bus_a.sig_in = 4'b0000;
    wait_out(1'b0, 4'b0000, 12, e, r, f);
    chk("release_lat",  32'(e), 32'd6);
    chk("release_fall", 32'(f), 32'h1);
    chk("release_key",  32'(bus_a.key_pressed), 32'h0);

    // Bounce: each high burst lasts 3 samples, one short of acceptance
    bad = 0;
    for (int t = 0; t < 30; t++) begin
      if (t % 3 == 0) bus_a.sig_in[1] = ~bus_a.sig_in[1];
      tick();
      if (bus_a.sig_out != 4'b0000 || bus_a.rise_pulse != 4'b0000 || bus_a.fall_pulse != 4'b0000) bad++;
    end
    chk("bounce_glitches", 32'(bad), 32'd0);
    bus_a.sig_in = 4'b0010;
    wait_out(1'b0, 4'b0010, 12, e, r, f);
    chk("bounce_settle_lat",  32'(e), 32'd6);
    chk("bounce_settle_rise", 32'(r), 32'h2);
    bus_a.sig_in = 4'b0000;
    wait_out(1'b0, 4'b0000, 12, e, r, f);
    chk("bounce_release_fall", 32'(f), 32'h2);

    // Multi-key press and partial release
    bus_a.sig_in = 4'b0101;
    wait_out(1'b0, 4'b0101, 12, e, r, f);
    chk("multi_lat",   32'(e), 32'd6);
    chk("multi_rise",  32'(r), 32'h5);
    chk("multi_flags", 32'({bus_a.key_pressed, bus_a.multi_pressed}), 32'h3);
    tick();
    chk("multi_rise_1cyc", 32'(bus_a.rise_pulse), 32'h0);
    bus_a.sig_in = 4'b0100;
    wait_out(1'b0, 4'b0100, 12, e, r, f);
    chk("part_rel_fall",  32'(f), 32'h1);
    chk("part_rel_rise",  32'(r), 32'h0);
    chk("part_rel_flags", 32'({bus_a.key_pressed, bus_a.multi_pressed}), 32'h2);
    tick();
    chk("part_rel_fall_1cyc", 32'(bus_a.fall_pulse), 32'h0);
    bus_a.sig_in = 4'b0000;
    wait_out(1'b0, 4'b0000, 12, e, r, f);
    chk("multi_clear_fall", 32'(f), 32'h4);

    // Enable gate
    bus_a.enable = 1'b0;
    bus_a.sig_in = 4'b1000;
    bad = 0;
    for (int t = 0; t < 20; t++) begin
      tick();
      if (bus_a.sig_out != 4'b0000 || bus_a.rise_pulse != 4'b0000 || bus_a.fall_pulse != 4'b0000) bad++;
    end
    chk("disabled_hold", 32'(bad), 32'd0);
    bus_a.enable = 1'b1;
    wait_out(1'b0, 4'b1000, 12, e, r, f);
    chk("reenable_lat",  32'(e), 32'd4);
    chk("reenable_rise", 32'(r), 32'h8);

    // Simultaneous rise on one channel and fall on another
    bus_a.sig_in = 4'b0001;
    wait_out(1'b0, 4'b0001, 12, e, r, f);
    chk("swap_lat",  32'(e), 32'd6);
    chk("swap_rise", 32'(r), 32'h1);
    chk("swap_fall", 32'(f), 32'h8);

    // Asynchronous reset between edges
    #2;
    reset = 1'b0;
    #1;
    chk("rst_mid_out",   32'(bus_a.sig_out), 32'h0);
    chk("rst_mid_flags", 32'({bus_a.key_pressed, bus_a.multi_pressed}), 32'h0);
    #3;
    reset = 1'b1;
    wait_out(1'b0, 4'b0001, 12, e, r, f);
    chk("rst_reacquire_lat", 32'(e), 32'd6);

    // Polarity: active-low instance has seen 1111 all along
    chk("pol_idle", 32'({bus_b.sig_out, bus_b.rise_pulse, bus_b.fall_pulse}), 32'h0);
    bus_b.sig_in = 4'b1110;
    wait_out(1'b1, 4'b0001, 12, e, r, f);
    chk("pol_lat",  32'(e), 32'd6);
    chk("pol_rise", 32'(r), 32'h1);
    chk("pol_key",  32'(bus_b.key_pressed), 32'h1);
    tick();
    chk("pol_rise_1cyc", 32'(bus_b.rise_pulse), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/multi_channel_debouncer.md
Name: multi_channel_debouncer

Overview:
Parametrised successor to the 4-bit keypad column debouncer. Filters WIDTH asynchronous, bouncy inputs such as keypad columns or buttons. Each input is synchronised, then must hold a new level for STABLE_CYCLES consecutive clocks before the clean output changes. Adds per-channel press/release pulses, input polarity selection, an enable gate, and aggregate pressed/multi-press flags for the keypad scanner FSM.

Parameters:
WIDTH, 4, number of independent channels
STABLE_CYCLES, 16, consecutive mismatching samples required to accept a new level (>=1)
SYNC_STAGES, 2, synchroniser flops per channel (>=2)
ACTIVE_HIGH, 1, 1: input high = active; 0: inputs inverted after synchroniser, so outputs are always active-high

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-low reset
sig_in  in  WIDTH  raw asynchronous inputs
enable  in  1  1: filtering runs; 0: counters cleared, outputs frozen
sig_out  out  WIDTH  debounced, registered, active-high levels
rise_pulse  out  WIDTH  one-cycle pulse when sig_out[i] goes 0->1
fall_pulse  out  WIDTH  one-cycle pulse when sig_out[i] goes 1->0
key_pressed  out  1  OR of sig_out
multi_pressed  out  1  high when two or more sig_out bits are set

Behaviour:
- Reset (reset=0, asynchronous): all synchroniser flops load the inactive level. Counters = 0. sig_out, rise_pulse and fall_pulse = 0. key_pressed and multi_pressed are therefore 0. Assertion mid-operation aborts any count in progress immediately. Release is sampled on the next clk rise.
- Synchroniser: SYNC_STAGES flops per channel, always clocked (enable does not gate it). Polarity normalisation is applied at the last stage; call this syn[i].
- Per-channel counter, width $clog2(STABLE_CYCLES)+1, updated on each clk rise with enable=1:
  - syn[i]==sig_out[i]: cnt <= 0. Any bounce restarts the count.
  - syn[i]!=sig_out[i] and cnt<STABLE_CYCLES-1: cnt <= cnt+1.
  - syn[i]!=sig_out[i] and cnt==STABLE_CYCLES-1: sig_out[i] <= syn[i], cnt <= 0, and the matching rise_pulse[i] or fall_pulse[i] <= 1.
  - The counter never wraps.
- STABLE_CYCLES=1: the output follows syn on the first mismatching edge.
- Pulses are registered and high for exactly one cycle, coincident with the first cycle of the new sig_out level. They default to 0 on every other edge.
- Latency: a clean input step at sig_in appears at sig_out after SYNC_STAGES+STABLE_CYCLES clk edges (±1 for asynchronous sampling phase).
- enable=0: cnt <= 0, sig_out holds, pulses 0. On re-enable, counting starts from 0. Changes present while disabled are accepted only after a full STABLE_CYCLES window.
- Channels are fully independent. Simultaneous acceptance on several channels produces simultaneous pulses.
- key_pressed and multi_pressed are combinational from registered sig_out only, with no path from sig_in.

Test Plan:
All scenarios use WIDTH=4, STABLE_CYCLES=4, SYNC_STAGES=2, ACTIVE_HIGH=1, enable=1 unless stated.
- Reset: drive reset=0 for 2 cycles, then 1 -> all outputs 0 throughout. Later, after sig_out=0001, assert reset between clock edges -> sig_out=0000 before the next clk edge.
- Clean press: sig_in 0000->0001, held -> sig_out=0001 within 6±1 edges. rise_pulse=0001 for exactly one cycle. key_pressed=1, multi_pressed=0.
- Bounce: toggle sig_in[1] every 3 cycles for 30 cycles -> sig_out stays 0000, no pulses. Then hold 0010 -> sig_out=0010 within 6±1 edges.
- Multi-key and release: sig_in=0101 -> sig_out=0101, rise_pulse=0101 in one cycle, multi_pressed=1. Then sig_in=0100 -> fall_pulse=0001 once, sig_out=0100, multi_pressed=0.
- Enable gate: enable=0, sig_in 0000->1000 for 20 cycles -> sig_out=0000, no pulses. Set enable=1 -> sig_out=1000 exactly 4 edges later.
- Polarity (ACTIVE_HIGH=0): idle sig_in=1111 -> sig_out=0000. sig_in=1110 held -> sig_out=0001, rise_pulse[0] once.
